// File: rtl/wb_interconnect_rr_mxs.sv
// wb_interconnect_rr_mxs: N_MASTERS x N_SLAVES Wishbone crossbar.
// Each slave has its own round-robin arbiter. A granted master stays locked to its
// slave until it drops CYC. Unmapped requests are answered by a one-cycle ERR responder.
// Optional feature macro: WB_IC_TIMEOUT_EN adds per-slave stall timeouts.
module wb_interconnect_rr_mxs #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES = 2,
  parameter logic [N_SLAVES*2*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_ADR,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_DAT_W,
  input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_SEL,
  input  logic [N_MASTERS*3-1:0]                 m_CTI,
  input  logic [N_MASTERS*2-1:0]                 m_BTE,
  input  logic [N_MASTERS-1:0]                   m_CYC,
  input  logic [N_MASTERS-1:0]                   m_STB,
  input  logic [N_MASTERS-1:0]                   m_WE,
  output logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_DAT_R,
  output logic [N_MASTERS-1:0]                   m_ACK,
  output logic [N_MASTERS-1:0]                   m_ERR,
  output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]      s_ADR,
  output logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_DAT_W,
  output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0]  s_SEL,
  output logic [N_SLAVES*3-1:0]                  s_CTI,
  output logic [N_SLAVES*2-1:0]                  s_BTE,
  output logic [N_SLAVES-1:0]                    s_CYC,
  output logic [N_SLAVES-1:0]                    s_STB,
  output logic [N_SLAVES-1:0]                    s_WE,
  input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_DAT_R,
  input  logic [N_SLAVES-1:0]                    s_ACK,
  input  logic [N_SLAVES-1:0]                    s_ERR
);

  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} arb_state_t;

  arb_state_t           r_state [N_SLAVES];
  logic [MW-1:0]        r_grant [N_SLAVES];
  logic [MW-1:0]        r_last  [N_SLAVES];
  logic [N_MASTERS-1:0] r_err_rsp;

  logic [N_SLAVES-1:0]  w_busy, w_gcyc, w_gstb, w_release, w_any, w_to_hit;
  logic [N_SLAVES-1:0]  w_in  [N_MASTERS];   // address falls in window j
  logic [N_SLAVES-1:0]  w_sel [N_MASTERS];   // decoded target, lowest window wins
  logic [N_MASTERS-1:0] w_req [N_SLAVES];
  logic [N_MASTERS-1:0] w_own [N_SLAVES];    // one-hot owner of each busy slave
  logic [N_MASTERS-1:0] w_locked, w_unmapped;
  logic [MW-1:0]        w_pick [N_SLAVES];

  // Window bounds come from the packed table, slave 0 in the most significant pair
  for (genvar j = 0; j < N_SLAVES; j++) begin : g_win
    localparam int BASE_LSB = (N_SLAVES - 1 - j) * 2 * AW + AW;
    localparam int LIM_LSB  = (N_SLAVES - 1 - j) * 2 * AW;
    assign w_busy[j] = (r_state[j] == ST_BUSY);
    for (genvar i = 0; i < N_MASTERS; i++) begin : g_cmp
      assign w_in[i][j] = (m_ADR[i*AW +: AW] >= ADDR_RANGES[BASE_LSB +: AW]) &&
                          (m_ADR[i*AW +: AW] <= ADDR_RANGES[LIM_LSB +: AW]);
    end
  end

  // Ownership: which master drives each busy slave, and which masters are locked
  always_comb begin
    w_locked = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      w_own[j]  = '0;
      w_gcyc[j] = 1'b0;
      w_gstb[j] = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
        w_own[j][i] = w_busy[j] & (r_grant[j] == MW'(i));
        w_gcyc[j]   = w_gcyc[j] | (w_own[j][i] & m_CYC[i]);
        w_gstb[j]   = w_gstb[j] | (w_own[j][i] & m_STB[i]);
        w_locked[i] = w_locked[i] | w_own[j][i];
      end
    end
  end

  // Address decode: first matching window wins; a locked master never re-decodes
  always_comb begin
    logic v_hit;
    v_hit = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      v_hit    = 1'b0;
      w_sel[i] = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
        w_sel[i][j] = m_CYC[i] & m_STB[i] & ~v_hit & w_in[i][j];
        v_hit       = v_hit | w_in[i][j];
      end
      w_unmapped[i] = m_CYC[i] & m_STB[i] & ~v_hit & ~w_locked[i];
    end
  end

  // Per-slave requests and round-robin pick scanning upward from last grant + 1
  always_comb begin
    for (int j = 0; j < N_SLAVES; j++) begin
      w_req[j] = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        w_req[j][i] = w_sel[i][j] & ~w_locked[i];
      end
      w_any[j]  = |w_req[j];
      w_pick[j] = r_last[j];
      // Larger offsets first so the nearest requester after last grant overrides
      for (int k = N_MASTERS; k >= 1; k--) begin
        for (int i = 0; i < N_MASTERS; i++) begin
          w_pick[j] = (w_req[j][i] && (r_last[j] == MW'((i + N_MASTERS - k) % N_MASTERS)))
                      ? MW'(i) : w_pick[j];
        end
      end
      w_release[j] = w_busy[j] & (~w_gcyc[j] | w_to_hit[j]);
    end
  end

  // Arbiter FSM per slave: grant on request, hand over on the release edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        r_state[j] <= ST_IDLE;
        r_grant[j] <= '0;
        r_last[j]  <= MW'(N_MASTERS - 1);
      end
    end else begin
      for (int j = 0; j < N_SLAVES; j++) begin
        case (r_state[j])
          ST_IDLE: begin
            if (w_any[j]) begin
              r_state[j] <= ST_BUSY;
              r_grant[j] <= w_pick[j];
              r_last[j]  <= w_pick[j];
            end else begin
              r_state[j] <= ST_IDLE;
            end
          end
          ST_BUSY: begin
            if (w_to_hit[j]) begin
              // Forced idle: keep CYC low for a cycle before any re-grant
              r_state[j] <= ST_IDLE;
            end else if (w_release[j] && w_any[j]) begin
              r_state[j] <= ST_BUSY;
              r_grant[j] <= w_pick[j];
              r_last[j]  <= w_pick[j];
            end else if (w_release[j]) begin
              r_state[j] <= ST_IDLE;
            end else begin
              r_state[j] <= ST_BUSY;
            end
          end
          default: r_state[j] <= ST_IDLE;
        endcase
      end
    end
  end

  // Error responder: one ERR cycle per sampled unmapped strobe, re-arming each other edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_rsp <= '0;
    end else begin
      r_err_rsp <= w_unmapped & ~r_err_rsp;
    end
  end

`ifdef WB_IC_TIMEOUT_EN
  logic [15:0] r_to_cnt [N_SLAVES];

  // Timeout fires on the stalled cycle that would bring the count to the limit
  always_comb begin
    for (int j = 0; j < N_SLAVES; j++) begin
      w_to_hit[j] = w_busy[j] & w_gstb[j] & ~s_ACK[j] & ~s_ERR[j] &
                    (r_to_cnt[j] == 16'(TIMEOUT_CYCLES - 1));
    end
  end

  // Stall counters: count unanswered strobes, clear on a response or end of grant
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        r_to_cnt[j] <= 16'd0;
      end
    end else begin
      for (int j = 0; j < N_SLAVES; j++) begin
        if (~w_busy[j] | w_release[j] | s_ACK[j] | s_ERR[j]) begin
          r_to_cnt[j] <= 16'd0;
        end else if (w_gstb[j]) begin
          r_to_cnt[j] <= r_to_cnt[j] + 16'd1;
        end else begin
          r_to_cnt[j] <= r_to_cnt[j];
        end
      end
    end
  end
`else
  // Timeouts compiled out: a silent slave holds its master indefinitely
  always_comb begin
    w_to_hit = '0;
  end
`endif

  // Crossbar datapath: AND-OR muxes, owners are one-hot so idle paths stay zero
  always_comb begin
    s_ADR   = '0;
    s_DAT_W = '0;
    s_SEL   = '0;
    s_CTI   = '0;
    s_BTE   = '0;
    s_CYC   = '0;
    s_STB   = '0;
    s_WE    = '0;
    m_DAT_R = '0;
    m_ACK   = '0;
    m_ERR   = r_err_rsp;
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        s_ADR[j*AW +: AW]   = s_ADR[j*AW +: AW]   | ({AW{w_own[j][i]}} & m_ADR[i*AW +: AW]);
        s_DAT_W[j*DW +: DW] = s_DAT_W[j*DW +: DW] | ({DW{w_own[j][i]}} & m_DAT_W[i*DW +: DW]);
        s_SEL[j*SW +: SW]   = s_SEL[j*SW +: SW]   | ({SW{w_own[j][i]}} & m_SEL[i*SW +: SW]);
        s_CTI[j*3 +: 3]     = s_CTI[j*3 +: 3]     | ({3{w_own[j][i]}} & m_CTI[i*3 +: 3]);
        s_BTE[j*2 +: 2]     = s_BTE[j*2 +: 2]     | ({2{w_own[j][i]}} & m_BTE[i*2 +: 2]);
        s_CYC[j]            = s_CYC[j] | (w_own[j][i] & m_CYC[i]);
        s_STB[j]            = s_STB[j] | (w_own[j][i] & m_STB[i]);
        s_WE[j]             = s_WE[j]  | (w_own[j][i] & m_WE[i]);
        m_DAT_R[i*DW +: DW] = m_DAT_R[i*DW +: DW] | ({DW{w_own[j][i]}} & s_DAT_R[j*DW +: DW]);
        m_ACK[i]            = m_ACK[i] | (w_own[j][i] & s_ACK[j]);
        m_ERR[i]            = m_ERR[i] | (w_own[j][i] & (s_ERR[j] | w_to_hit[j]));
      end
    end
  end

endmodule

// File: tb/tb_wb_interconnect_rr_mxs.sv
// Testbench for wb_interconnect_rr_mxs, 2 masters x 2 slaves.
// Slave 0 window [0x0000_0000, 0x0000_FFFF], slave 1 window [0x0001_0000, 0x0001_FFFF].
module tb_wb_interconnect_rr_mxs;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] m_ADR, m_DAT_W, m_DAT_R;
  logic [7:0]  m_SEL;
  logic [5:0]  m_CTI;
  logic [3:0]  m_BTE;
  logic [1:0]  m_CYC, m_STB, m_WE, m_ACK, m_ERR;
  logic [63:0] s_ADR, s_DAT_W, s_DAT_R;
  logic [7:0]  s_SEL;
  logic [5:0]  s_CTI;
  logic [3:0]  s_BTE;
  logic [1:0]  s_CYC, s_STB, s_WE, s_ACK, s_ERR;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  wb_interconnect_rr_mxs #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_MASTERS(2), .N_SLAVES(2),
    .ADDR_RANGES({32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF}),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_ADR(m_ADR), .m_DAT_W(m_DAT_W), .m_SEL(m_SEL), .m_CTI(m_CTI), .m_BTE(m_BTE),
    .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE),
    .m_DAT_R(m_DAT_R), .m_ACK(m_ACK), .m_ERR(m_ERR),
    .s_ADR(s_ADR), .s_DAT_W(s_DAT_W), .s_SEL(s_SEL), .s_CTI(s_CTI), .s_BTE(s_BTE),
    .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE),
    .s_DAT_R(s_DAT_R), .s_ACK(s_ACK), .s_ERR(s_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  cyc;
    logic [31:0] adr0;
    logic [31:0] adr1;
    logic [1:0]  exp_scyc;
    logic [1:0]  exp_err;
    int          g0;
    int          g1;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    m_CYC = 2'b00;
    m_STB = 2'b00;
    tick();
    tick();
  endtask

  // Expected slave-side bundle when master g owns the slave (g < 0: idle, all zero)
  function automatic logic [127:0] exp_view(input int g);
    if (g < 0) return 128'd0;
    return {54'd0, m_ADR[g*32 +: 32], m_DAT_W[g*32 +: 32], m_SEL[g*4 +: 4],
            m_CTI[g*3 +: 3], m_BTE[g*2 +: 2], m_WE[g]};
  endfunction

  function automatic logic [127:0] act_view(input int j);
    return {54'd0, s_ADR[j*32 +: 32], s_DAT_W[j*32 +: 32], s_SEL[j*4 +: 4],
            s_CTI[j*3 +: 3], s_BTE[j*2 +: 2], s_WE[j]};
  endfunction

  // Scoreboard: every master ACK pops the data expected for that master
  always @(negedge clk) begin
    if (!rst) begin
      if (m_ACK[0]) begin
        if (q0.size() == 0) chk("ack0_unexpected", 128'(m_ACK[0]), 128'd0);
        else chk("ack0_data", 128'(m_DAT_R[31:0]), 128'(q0.pop_front()));
      end
      if (m_ACK[1]) begin
        if (q1.size() == 0) chk("ack1_unexpected", 128'(m_ACK[1]), 128'd0);
        else chk("ack1_data", 128'(m_DAT_R[63:32]), 128'(q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"m0_s0",    2'b01, 32'h0000_0100, 32'h0000_0000, 2'b01, 2'b00,  0, -1};
    vecs[1] = '{"m1_s1",    2'b10, 32'h0000_0000, 32'h0001_0200, 2'b10, 2'b00, -1,  1};
    vecs[2] = '{"m0_s1_b",  2'b01, 32'h0001_0000, 32'h0000_0000, 2'b10, 2'b00, -1,  0};
    vecs[3] = '{"m1_s0_l",  2'b10, 32'h0000_0000, 32'h0000_FFFF, 2'b01, 2'b00,  1, -1};
    vecs[4] = '{"cross",    2'b11, 32'h0001_FFFF, 32'h0000_0000, 2'b11, 2'b00,  1,  0};
    vecs[5] = '{"m0_unm",   2'b01, 32'h0002_0000, 32'h0000_0000, 2'b00, 2'b01, -1, -1};
    vecs[6] = '{"both_unm", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 2'b00, 2'b11, -1, -1};
    vecs[7] = '{"mix",      2'b11, 32'h0000_0040, 32'h0002_0000, 2'b01, 2'b10,  0, -1};
    vecs[8] = '{"none",     2'b00, 32'h0000_0040, 32'h0001_0040, 2'b00, 2'b00, -1, -1};

    m_ADR = 64'd0;
    m_DAT_W = {32'hBBBB_0001, 32'hAAAA_0000};
    m_SEL = 8'h3C;
    m_CTI = {3'b111, 3'b010};
    m_BTE = {2'b10, 2'b01};
    m_WE = 2'b10;
    m_CYC = 2'b00;
    m_STB = 2'b00;
    s_DAT_R = 64'd0;
    s_ACK = 2'b00;
    s_ERR = 2'b00;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 128'({s_CYC, s_STB, m_ACK, m_ERR}), 128'd0);
    chk("reset_sadr", 128'(s_ADR), 128'd0);
    rst = 1'b0;

    // Contention on slave 0 after reset: m0 first, then m1 with no idle cycle
    m_ADR = {32'h0000_0200, 32'h0000_0100};
    m_CYC = 2'b11;
    m_STB = 2'b11;
    tick();
    chk("arb_first_scyc", 128'(s_CYC), 128'(2'b01));
    chk("arb_first_adr", 128'(s_ADR[31:0]), 128'h100);
    s_ACK = 2'b01;
    s_DAT_R = {32'h0, 32'h1234_5678};
    q0.push_back(32'h1234_5678);
    #1;
    chk("arb_ack_route", 128'(m_ACK), 128'(2'b01));
    @(negedge clk);
    #1;
    s_ACK = 2'b00;
    m_CYC[0] = 1'b0;
    m_STB[0] = 1'b0;
    tick();
    chk("handover_scyc", 128'(s_CYC), 128'(2'b01));
    chk("handover_adr", 128'(s_ADR[31:0]), 128'h200);
    release_all();

    // Concurrent transfers to different slaves, each gets its own data
    m_ADR = {32'h0001_0010, 32'h0000_0010};
    m_CYC = 2'b11;
    m_STB = 2'b11;
    tick();
    chk("conc_scyc", 128'(s_CYC), 128'(2'b11));
    s_ACK = 2'b11;
    s_DAT_R = {32'h5A5A_0002, 32'hA5A5_0001};
    q0.push_back(32'hA5A5_0001);
    q1.push_back(32'h5A5A_0002);
    @(negedge clk);
    #1;
    s_ACK = 2'b00;
    s_DAT_R = 64'd0;
    release_all();

    // Table: single-edge decode/forwarding vectors from an idle fabric
    for (int v = 0; v < 9; v++) begin
      m_ADR = {vecs[v].adr1, vecs[v].adr0};
      m_CYC = vecs[v].cyc;
      m_STB = vecs[v].cyc;
      tick();
      chk({vecs[v].name, "_scyc"}, 128'(s_CYC), 128'(vecs[v].exp_scyc));
      chk({vecs[v].name, "_sstb"}, 128'(s_STB), 128'(vecs[v].exp_scyc));
      chk({vecs[v].name, "_merr"}, 128'(m_ERR), 128'(vecs[v].exp_err));
      chk({vecs[v].name, "_s0"}, act_view(0), exp_view(vecs[v].g0));
      chk({vecs[v].name, "_s1"}, act_view(1), exp_view(vecs[v].g1));
      release_all();
    end

    // Held unmapped strobe: ERR on alternate cycles, no slave cycle
    m_ADR = {32'h0, 32'h8000_0000};
    m_CYC = 2'b01;
    m_STB = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("unm_err_pulse", 128'(m_ERR), 128'((k % 2 == 1) ? 2'b01 : 2'b00));
      chk("unm_scyc", 128'(s_CYC), 128'd0);
    end
    release_all();

    // Locked target: address moves into slave 1 window while CYC is held
    m_ADR = {32'h0, 32'h0000_0040};
    m_CYC = 2'b01;
    m_STB = 2'b01;
    tick();
    chk("lock_grant", 128'(s_CYC), 128'(2'b01));
    m_ADR = {32'h0, 32'h0001_0040};
    tick();
    tick();
    chk("lock_scyc", 128'(s_CYC), 128'(2'b01));
    chk("lock_adr", 128'(s_ADR[31:0]), 128'h0001_0040);
    chk("lock_noerr", 128'(m_ERR), 128'd0);
    s_ERR = 2'b01;
    #1;
    chk("slave_err_route", 128'(m_ERR), 128'(2'b01));
    s_ERR = 2'b00;

    // Reset mid-transfer with m1 waiting; afterwards m0 must win again
    m_ADR = {32'h0000_0300, 32'h0000_0050};
    m_CYC = 2'b11;
    m_STB = 2'b11;
    tick();
    rst = 1'b1;
    tick();
    s_ACK = 2'b01;
    #1;
    chk("rst_mid_outputs", 128'({s_CYC, s_STB, m_ACK, m_ERR}), 128'd0);
    s_ACK = 2'b00;
    rst = 1'b0;
    tick();
    chk("rst_regrant_scyc", 128'(s_CYC), 128'(2'b01));
    chk("rst_regrant_m0", 128'(s_ADR[31:0]), 128'h50);
    release_all();

`ifdef WB_IC_TIMEOUT_EN
    // Silent slave: ERR on the TO-th stalled cycle, then CYC low for a cycle
    m_ADR = {32'h0, 32'h0000_0060};
    m_CYC = 2'b01;
    m_STB = 2'b01;
    tick();
    for (int k = 1; k <= TO; k++) begin
      chk("to_err", 128'(m_ERR[0]), 128'(k == TO));
      if (k < TO) tick();
    end
    tick();
    chk("to_cyc_low", 128'(s_CYC[0]), 128'd0);
    release_all();
`endif

    chk("sb_drained", 128'(q0.size() + q1.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
